// File: rtl/sonic_rx_dma_reader.sv
// sonic_rx_dma_reader
// Pulls fixed-size bursts of owords out of the SoNIC RX ring and hands them
// to the DMA write requester.  Reads are issued only when there is room in a
// small skid FIFO for every read already in flight, so a DMA stall can never
// overflow the FIFO.  Steady-state throughput is one beat per cycle.

`ifndef RX_READ_ADDR_WIDTH
`define RX_READ_ADDR_WIDTH 12
`endif
`ifndef USED_QWORDS_WIDTH
`define USED_QWORDS_WIDTH 13
`endif

module sonic_rx_dma_reader #(
    parameter int OUTPUT_WIDTH = 128,
    parameter int ADDR_WIDTH   = `RX_READ_ADDR_WIDTH,
    parameter int BURST_OWORDS = 16,
    parameter int RAM_LATENCY  = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [`USED_QWORDS_WIDTH-1:0] rdusedqwords,
    input  logic [OUTPUT_WIDTH-1:0]       read_data,
    output logic [ADDR_WIDTH-1:0]         rd_address_owords,
    output logic                          rdreq,
    output logic                          rdena,
    output logic [OUTPUT_WIDTH-1:0]       dma_data,
    output logic                          dma_valid,
    output logic                          dma_sop,
    output logic                          dma_eop,
    input  logic                          waitrequest,
    output logic                          busy,
    output logic [31:0]                   bursts_done
);

    // ------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------
    // Skid FIFO holds one entry per read that can be outstanding.
    localparam int DEPTH  = RAM_LATENCY + 1;
    // DEPTH is 2..4, so one or two pointer bits are enough.
    localparam int PTR_W  = (DEPTH > 2) ? 2 : 1;
    // Occupancy counter holds 0..DEPTH.
    localparam int CNT_W  = 3;
    // FIFO occupancy plus in-flight reads can briefly reach DEPTH+RAM_LATENCY.
    localparam int OCC_W  = 4;
    localparam int BEAT_W = (BURST_OWORDS > 1) ? $clog2(BURST_OWORDS) : 1;
    localparam int UQW    = `USED_QWORDS_WIDTH;

    // The ring reports qwords; a burst needs two qwords per oword.
    localparam logic [UQW-1:0]    START_LEVEL = UQW'(2 * BURST_OWORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_OWORDS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR    = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state_q;
    state_t                  state_d;
    logic [BEAT_W-1:0]       issue_cnt_q;   // reads issued in current burst
    logic [BEAT_W-1:0]       beat_q;        // beats transferred in current burst
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [RAM_LATENCY-1:0]  pipe_q;        // bit i set: a read issued i+1 cycles ago
    logic [OUTPUT_WIDTH-1:0] fifo_mem [0:DEPTH-1];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [31:0]             bursts_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             push;
    logic             pop;
    logic             eop_xfer;
    logic             can_issue;
    logic [OCC_W-1:0] inflight;
    logic [OCC_W-1:0] occupancy;

    // DMA handshake: a beat transfers in any cycle where dma_valid=1 and
    // waitrequest=0.  While dma_valid=1 and waitrequest=1 the head of the FIFO
    // and the beat counter are frozen, so dma_data/dma_sop/dma_eop hold.
    // dma_valid never depends on waitrequest.
    assign dma_valid = (count_q != '0);
    assign dma_data  = fifo_mem[rd_ptr_q];
    assign dma_sop   = dma_valid && (beat_q == '0);
    assign dma_eop   = dma_valid && (beat_q == LAST_BEAT);
    assign pop       = dma_valid && !waitrequest;
    assign eop_xfer  = pop && dma_eop;

    // Data for a read issued RAM_LATENCY cycles ago is on read_data now.
    assign push      = pipe_q[RAM_LATENCY-1];

    assign rd_address_owords = addr_q;
    assign rdena             = 1'b1;
    assign busy              = (state_q != IDLE);
    assign bursts_done       = bursts_q;

    // Count reads still travelling through the RAM pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            inflight = inflight + OCC_W'(pipe_q[i]);
        end
    end

    // Occupancy is what the FIFO will hold once this cycle's pop (if any)
    // leaves, plus every read that will still land in it.  Counting the pop
    // lets a new read go out every cycle while the DMA is draining, and a
    // new read is only allowed if its data is guaranteed a slot.
    always_comb begin
        occupancy = OCC_W'(count_q) + inflight - OCC_W'(pop);
        can_issue = (occupancy < OCC_W'(DEPTH));
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // Next-state and read-issue decode.
    always_comb begin
        state_d = state_q;
        rdreq   = 1'b0;
        case (state_q)
            IDLE: begin
                // Wait for a full burst to be sitting in the ring.
                if (enable && (rdusedqwords >= START_LEVEL)) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // enable is ignored here: a started burst always completes.
                if (can_issue) begin
                    rdreq = 1'b1;
                    if (issue_cnt_q == LAST_BEAT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (eop_xfer) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read address and per-burst issue count; both advance once per read.
    // The issue count is BEAT_W bits wide so it returns to zero by itself
    // after the last read of a burst.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q      <= '0;
            issue_cnt_q <= '0;
        end else if (rdreq) begin
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            issue_cnt_q <= issue_cnt_q + BEAT_W'(1);
        end
    end

    // Track reads travelling through the RAM read pipeline.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pipe_q <= '0;
        end else begin
            for (int i = RAM_LATENCY - 1; i > 0; i--) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            pipe_q[0] <= rdreq;
        end
    end

    // ------------------------------------------------------------------
    // Skid FIFO
    // ------------------------------------------------------------------
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // FIFO pointers and occupancy; push and pop together leave it unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= read_data;
        end
    end

    // ------------------------------------------------------------------
    // Beat framing and statistics
    // ------------------------------------------------------------------
    // Beat position within the burst (wraps at BURST_OWORDS) and the
    // completed-burst counter (wraps at 2^32).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beat_q   <= '0;
            bursts_q <= '0;
        end else begin
            if (pop) begin
                beat_q <= beat_q + BEAT_W'(1);
            end
            if (eop_xfer) begin
                bursts_q <= bursts_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_sonic_rx_dma_reader.sv
// Bench for sonic_rx_dma_reader: a ring RAM model with fixed latency, a
// behavioural burst model with an expected-data queue checked every cycle,
// and a directed sequence of scenarios with hand-computed expectations.

`ifndef USED_QWORDS_WIDTH
`define USED_QWORDS_WIDTH 13
`endif

module tb_sonic_rx_dma_reader;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int BURST = 16;
  localparam int LAT   = 2;
  localparam int UQW   = `USED_QWORDS_WIDTH;
  localparam int RING  = 1 << AW;

  // ---------------- clock / reset / DUT ----------------
  logic           clk;
  logic           reset_n;
  logic           enable;
  logic [UQW-1:0] rdusedqwords;
  logic [DW-1:0]  read_data;
  logic [AW-1:0]  rd_address_owords;
  logic           rdreq;
  logic           rdena;
  logic [DW-1:0]  dma_data;
  logic           dma_valid;
  logic           dma_sop;
  logic           dma_eop;
  logic           waitrequest;
  logic           busy;
  logic [31:0]    bursts_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sonic_rx_dma_reader #(
    .OUTPUT_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BURST_OWORDS(BURST),
    .RAM_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .rdusedqwords(rdusedqwords),
    .read_data(read_data),
    .rd_address_owords(rd_address_owords),
    .rdreq(rdreq),
    .rdena(rdena),
    .dma_data(dma_data),
    .dma_valid(dma_valid),
    .dma_sop(dma_sop),
    .dma_eop(dma_eop),
    .waitrequest(waitrequest),
    .busy(busy),
    .bursts_done(bursts_done)
  );

  // ---------------- counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- ring RAM model ----------------
  // Address seen in cycle t produces data on read_data for the capture edge
  // LAT cycles after the read is accepted.
  logic [DW-1:0] mem  [0:RING-1];
  logic [DW-1:0] hist [0:LAT];

  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0]   = rdreq ? mem[rd_address_owords] : 32'hDEAD_BEEF;
    read_data = hist[LAT];
  end

  // ---------------- behavioural model + scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int model_addr, beat_idx, model_bursts, reads_in_burst, outstanding;
  int rdreq_total = 0, beat_total = 0, sop_total = 0, eop_total = 0;
  int cyc = 0, lat_cnt = 0, first_lat = -1, first_beat_cyc = 0, eop_cyc = 0;
  bit lat_armed = 0, prev_rst = 0, prev_stall = 0, prev_busy = 0;
  logic [DW-1:0] held_data;
  logic held_sop, held_eop;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      model_addr     = 0;
      beat_idx       = 0;
      model_bursts   = 0;
      reads_in_burst = 0;
      outstanding    = 0;
      prev_rst       = 1;
      prev_stall     = 0;
      prev_busy      = 0;
      lat_armed      = 0;
    end else begin
      if (prev_rst) begin
        check("post_reset_valid", 64'(dma_valid), 64'(0));
        check("post_reset_addr", 64'(rd_address_owords), 64'(0));
        prev_rst = 0;
      end
      check("rdena", 64'(rdena), 64'(1));
      check("bursts_done", 64'(bursts_done), 64'(model_bursts));

      // latency from burst start to first valid beat
      if (busy && !prev_busy) begin
        lat_armed = 1;
        lat_cnt   = 0;
      end else if (lat_armed) begin
        lat_cnt++;
        if (dma_valid) begin
          first_lat      = lat_cnt;
          first_beat_cyc = cyc;
          lat_armed      = 0;
        end
      end
      prev_busy = busy;

      // read side: addresses follow a contiguous wrapping sequence
      if (rdreq) begin
        check("rd_addr", 64'(rd_address_owords), 64'(model_addr));
        exp_q.push_back(mem[model_addr]);
        model_addr = (model_addr + 1) % RING;
        reads_in_burst++;
        rdreq_total++;
        outstanding++;
        check("reads_per_burst_ok", 64'(reads_in_burst <= BURST), 64'(1));
      end

      // held beat must not change while stalled
      if (prev_stall) begin
        check("stall_valid", 64'(dma_valid), 64'(1));
        check("stall_data", 64'(dma_data), 64'(held_data));
        check("stall_sop", 64'(dma_sop), 64'(held_sop));
        check("stall_eop", 64'(dma_eop), 64'(held_eop));
      end

      // DMA side: in-order data with burst framing
      if (dma_valid) begin
        check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          check("dma_data", 64'(dma_data), 64'(exp_q[0]));
        end
        check("dma_sop", 64'(dma_sop), 64'(beat_idx == 0));
        check("dma_eop", 64'(dma_eop), 64'(beat_idx == BURST - 1));
        held_data  = dma_data;
        held_sop   = dma_sop;
        held_eop   = dma_eop;
        prev_stall = waitrequest;
        if (!waitrequest) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          beat_total++;
          outstanding--;
          if (dma_sop) sop_total++;
          if (dma_eop) eop_total++;
          if (beat_idx == BURST - 1) begin
            model_bursts++;
            reads_in_burst = 0;
            eop_cyc        = cyc;
            beat_idx       = 0;
          end else begin
            beat_idx++;
          end
        end
      end else begin
        prev_stall = 0;
      end
      check("outstanding_ok", 64'(outstanding <= LAT + 1), 64'(1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_busy(input string name, input int limit);
    int n = 0;
    while (!busy && n < limit) begin
      tick(1);
      n++;
    end
    check({name, "_busy_seen"}, 64'(busy), 64'(1));
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick(1);
      n++;
    end
    check({name, "_idle_seen"}, 64'(busy), 64'(0));
  endtask

  task automatic wait_beats(input string name, input int target, input int limit);
    int n = 0;
    while (beat_total < target && n < limit) begin
      tick(1);
      n++;
    end
    check({name, "_beats_reached"}, 64'(beat_total >= target), 64'(1));
  endtask

  // Start one burst with enable dropped as soon as ISSUE is entered.
  task automatic start_burst(input string name);
    rdusedqwords = UQW'(2 * BURST);
    enable       = 1'b1;
    wait_busy(name, 20);
    enable = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int b_rd, b_beat, b_sop, b_eop;
  logic [7:0] pat;

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    rdusedqwords = '0;
    waitrequest  = 1'b0;
    read_data    = '0;
    for (int i = 0; i <= LAT; i++) hist[i] = '0;
    for (int i = 0; i < RING; i++) mem[i] = $urandom;
    tick(3);

    // reset state
    check("rst_addr", 64'(rd_address_owords), 64'(0));
    check("rst_rdreq", 64'(rdreq), 64'(0));
    check("rst_valid", 64'(dma_valid), 64'(0));
    check("rst_sop", 64'(dma_sop), 64'(0));
    check("rst_eop", 64'(dma_eop), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_bursts", 64'(bursts_done), 64'(0));
    check("rst_rdena", 64'(rdena), 64'(1));
    reset_n = 1'b1;
    tick(1);

    // A: one qword short of a burst -> nothing happens
    rdusedqwords = UQW'(31);
    enable       = 1'b1;
    tick(40);
    check("a_busy", 64'(busy), 64'(0));
    check("a_rdreq_total", 64'(rdreq_total), 64'(0));
    enable = 1'b0;
    tick(2);

    // B: exactly one burst worth, no stalls
    b_rd = rdreq_total; b_beat = beat_total; b_sop = sop_total; b_eop = eop_total;
    start_burst("b");
    wait_idle("b", 100);
    check("b_reads", 64'(rdreq_total - b_rd), 64'(16));
    check("b_beats", 64'(beat_total - b_beat), 64'(16));
    check("b_sops", 64'(sop_total - b_sop), 64'(1));
    check("b_eops", 64'(eop_total - b_eop), 64'(1));
    check("b_first_latency", 64'(first_lat), 64'(3));
    check("b_back_to_back", 64'(eop_cyc - first_beat_cyc), 64'(15));
    check("b_bursts_done", 64'(bursts_done), 64'(1));
    check("b_addr_after", 64'(rd_address_owords), 64'(16));

    // C: 10-cycle stall after beat 5; addresses 16..31 then wrap to 0
    b_beat = beat_total;
    start_burst("c");
    wait_beats("c", b_beat + 5, 50);
    waitrequest = 1'b1;
    tick(10);
    waitrequest = 1'b0;
    wait_idle("c", 100);
    check("c_beats", 64'(beat_total - b_beat), 64'(16));
    check("c_bursts_done", 64'(bursts_done), 64'(2));
    check("c_addr_wrapped", 64'(rd_address_owords), 64'(0));

    // D: enable held into ISSUE, then dropped; exactly one burst runs
    b_rd = rdreq_total; b_beat = beat_total;
    rdusedqwords = UQW'(2 * BURST);
    enable       = 1'b1;
    wait_busy("d", 20);
    tick(3);
    enable = 1'b0;
    wait_idle("d", 100);
    tick(20);
    check("d_reads", 64'(rdreq_total - b_rd), 64'(16));
    check("d_beats", 64'(beat_total - b_beat), 64'(16));
    check("d_stays_idle", 64'(busy), 64'(0));
    check("d_bursts_done", 64'(bursts_done), 64'(3));
    check("d_addr_after", 64'(rd_address_owords), 64'(16));

    // E: reset at beat 5, then a clean burst from address 0
    b_beat = beat_total;
    start_burst("e");
    wait_beats("e", b_beat + 5, 50);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("e_bursts_cleared", 64'(bursts_done), 64'(0));
    check("e_addr_cleared", 64'(rd_address_owords), 64'(0));
    tick(5);
    b_beat = beat_total; b_sop = sop_total;
    start_burst("e2");
    wait_idle("e2", 100);
    check("e_beats", 64'(beat_total - b_beat), 64'(16));
    check("e_sops", 64'(sop_total - b_sop), 64'(1));
    check("e_bursts_done", 64'(bursts_done), 64'(1));
    check("e_addr_after", 64'(rd_address_owords), 64'(16));

    // G: two back-to-back bursts across the ring wrap with a stall pattern
    b_beat       = beat_total;
    pat          = 8'b0110_0100;
    rdusedqwords = UQW'(4 * BURST);
    enable       = 1'b1;
    for (int k = 0; k < 400; k++) begin
      waitrequest = pat[k % 8];
      if (enable && busy && bursts_done == 32'd2) enable = 1'b0;
      if (!enable && !busy) break;
      tick(1);
    end
    waitrequest = 1'b0;
    enable      = 1'b0;
    check("g_idle", 64'(busy), 64'(0));
    check("g_beats", 64'(beat_total - b_beat), 64'(32));
    check("g_bursts_done", 64'(bursts_done), 64'(3));
    check("g_addr_after", 64'(rd_address_owords), 64'(16));
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
